mod_updn_cntr: RTL and testbench

Parametrised up/down counter: the successor to the team's fixed 4-bit free-running up counter. Adds configurable width and modulus, direction control, count enable, synchronous parallel load, wrap or saturate mode, a combinational terminal-count flag, a registered boundary-event pulse, and a sticky overflow flag. Used as a general timebase, event counter and prescaler in the SKY130 RTL flows.

---
 rtl/mod_updn_cntr.sv | 114 +++++++++++
 tb/tb_mod_updn_cntr.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_updn_cntr.sv
// mod_updn_cntr: parametrised modulo up/down counter with optional saturation,
// synchronous clamped parallel load, combinational terminal count, a registered
// boundary-event pulse and a sticky overflow flag.
//
// Legal parameters: WIDTH 2..32, MODULUS 2..2**WIDTH, RESET_VAL < MODULUS.
// MODULUS is a 64-bit parameter so that 2**32 stays representable.
module mod_updn_cntr #(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MODULUS   = 16,
    parameter bit              SATURATE  = 1'b0,
    parameter int unsigned     RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             evt,
    output logic             ovf_sticky
);

    // The modulus needs WIDTH+1 bits when it equals 2**WIDTH; the largest
    // count value always fits in WIDTH bits.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             evt_q, evt_d;
    logic             ovf_q, ovf_d;

    logic             at_max;
    logic             at_min;
    logic             load_fits;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH:0]   cnt_plus;
    logic [WIDTH-1:0] cnt_minus;

    // Boundary detection, clamped load value and the two neighbouring counts.
    always_comb begin
        at_max       = (cnt_q == MAX_CNT);
        at_min       = (cnt_q == '0);
        load_fits    = ({1'b0, load_val} < MOD_EXT);
        load_clamped = load_fits ? load_val : MAX_CNT;
        cnt_plus     = {1'b0, cnt_q} + {1'b0, ONE};
        cnt_minus    = cnt_q - ONE;
    end

    // Next-state selection: load beats counting, counting beats hold.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the if/else leaves it unassigned and infers a latch.
        cnt_d = cnt_q;
        evt_d = 1'b0;
        ovf_d = ovf_q;

        if (load) begin
            cnt_d = load_clamped;
        end else if (en) begin
            if (up_dn) begin
                if (at_max) begin
                    evt_d = 1'b1;
                    cnt_d = SATURATE ? cnt_q : '0;
                end else begin
                    cnt_d = cnt_plus[WIDTH-1:0];
                end
            end else begin
                if (at_min) begin
                    evt_d = 1'b1;
                    cnt_d = SATURATE ? cnt_q : MAX_CNT;
                end else begin
                    cnt_d = cnt_minus;
                end
            end
        end

        // A boundary step on this edge beats a simultaneous clear request.
        if (evt_d) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            cnt_q <= RST_CNT;
            evt_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
            ovf_q <= ovf_d;
        end
    end

    // Terminal count follows the present count and direction, independent of en.
    always_comb begin
        tc = up_dn ? at_max : at_min;
    end

    assign cnt        = cnt_q;
    assign evt        = evt_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_mod_updn_cntr.sv
// Self-checking bench for mod_updn_cntr. Four instances with different
// parameter sets share one stimulus stream; each is compared every cycle
// against an arithmetic reference model, plus directed spot checks.
module tb_mod_updn_cntr;

    localparam int N = 4;

    // Instance parameter sets: 0 = defaults, 1 = mod 10 wrap,
    // 2 = mod 10 saturate, 3 = 5-bit mod 32 saturate with reset value 3.
    function automatic int mod_of(input int i);
        case (i)
            0:       return 16;
            1, 2:    return 10;
            default: return 32;
        endcase
    endfunction

    function automatic bit sat_of(input int i);
        return (i >= 2);
    endfunction

    function automatic int rst_of(input int i);
        return (i == 3) ? 3 : 0;
    endfunction

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [4:0] lv;
    logic       ovf_clr;

    logic [3:0]   cnt0, cnt1, cnt2;
    logic [4:0]   cnt3;
    logic [N-1:0] tc_v, evt_v, ovf_v;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model state.
    int m_cnt [N];
    bit m_evt [N];
    bit m_ovf [N];

    always #5 clk = ~clk;

    mod_updn_cntr #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0), .RESET_VAL(0)) u_d16 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv[3:0]), .ovf_clr(ovf_clr),
        .cnt(cnt0), .tc(tc_v[0]), .evt(evt_v[0]), .ovf_sticky(ovf_v[0])
    );

    mod_updn_cntr #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RESET_VAL(0)) u_m10w (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv[3:0]), .ovf_clr(ovf_clr),
        .cnt(cnt1), .tc(tc_v[1]), .evt(evt_v[1]), .ovf_sticky(ovf_v[1])
    );

    mod_updn_cntr #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .RESET_VAL(0)) u_m10s (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv[3:0]), .ovf_clr(ovf_clr),
        .cnt(cnt2), .tc(tc_v[2]), .evt(evt_v[2]), .ovf_sticky(ovf_v[2])
    );

    mod_updn_cntr #(.WIDTH(5), .MODULUS(32), .SATURATE(1'b1), .RESET_VAL(3)) u_m32s (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv), .ovf_clr(ovf_clr),
        .cnt(cnt3), .tc(tc_v[3]), .evt(evt_v[3]), .ovf_sticky(ovf_v[3])
    );

    function automatic logic [31:0] dut_cnt(input int i);
        case (i)
            0:       return {28'b0, cnt0};
            1:       return {28'b0, cnt1};
            2:       return {28'b0, cnt2};
            default: return {27'b0, cnt3};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the spec's rules directly.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            int m   = mod_of(i);
            int lvi = (i == 3) ? int'(lv) : int'(lv[3:0]);
            if (reset) begin
                m_cnt[i] = rst_of(i);
                m_evt[i] = 1'b0;
                m_ovf[i] = 1'b0;
            end else begin
                m_evt[i] = 1'b0;
                if (load) begin
                    m_cnt[i] = (lvi < m) ? lvi : m - 1;
                end else if (en) begin
                    int nxt = m_cnt[i] + (up_dn ? 1 : -1);
                    if (nxt < 0 || nxt >= m) begin
                        m_evt[i] = 1'b1;
                        if (!sat_of(i)) m_cnt[i] = (nxt + m) % m;
                    end else begin
                        m_cnt[i] = nxt;
                    end
                end
                if (m_evt[i])     m_ovf[i] = 1'b1;
                else if (ovf_clr) m_ovf[i] = 1'b0;
            end
        end
    endtask

    // One clock: model update at the edge, compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < N; i++) begin
            int  m      = mod_of(i);
            bit  exp_tc = up_dn ? (m_cnt[i] == m - 1) : (m_cnt[i] == 0);
            check($sformatf("cnt[%0d]", i), dut_cnt(i), m_cnt[i]);
            check($sformatf("tc[%0d]", i),  {31'b0, tc_v[i]},  {31'b0, exp_tc});
            check($sformatf("evt[%0d]", i), {31'b0, evt_v[i]}, {31'b0, m_evt[i]});
            check($sformatf("ovf[%0d]", i), {31'b0, ovf_v[i]}, {31'b0, m_ovf[i]});
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_evt[i] = 1'b0;
            m_ovf[i] = 1'b0;
        end
        reset = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; lv = '0; ovf_clr = 1'b0;

        // Reset held for six cycles.
        run(6);
        check("rst_cnt_d16", dut_cnt(0), 0);
        check("rst_cnt_rv3", dut_cnt(3), 3);
        check("rst_tc_dn",   {31'b0, tc_v[0]}, 1);

        // Count up from reset: default counter goes 0..15,0.
        reset = 1'b0; en = 1'b1; up_dn = 1'b1;
        run(15);
        check("top_cnt_d16", dut_cnt(0), 15);
        check("top_tc_d16",  {31'b0, tc_v[0]}, 1);
        run(1);
        check("wrap_cnt_d16", dut_cnt(0), 0);
        check("wrap_evt_d16", {31'b0, evt_v[0]}, 1);
        check("wrap_ovf_d16", {31'b0, ovf_v[0]}, 1);
        run(4);

        // Count down from reset: mod-10 wrap gives 9 on the first step.
        reset = 1'b1;
        run(1);
        reset = 1'b0; up_dn = 1'b0;
        run(1);
        check("dn_first_m10w", dut_cnt(1), 9);
        check("dn_evt_m10w",   {31'b0, evt_v[1]}, 1);
        run(11);

        // Saturate: load 7, count up 5 cycles, then reverse.
        load = 1'b1; lv = 5'd7; up_dn = 1'b1;
        run(1);
        load = 1'b0;
        run(5);
        check("sat_cnt_m10s", dut_cnt(2), 9);
        check("sat_evt_m10s", {31'b0, evt_v[2]}, 1);
        up_dn = 1'b0;
        run(1);
        check("sat_rev_m10s", dut_cnt(2), 8);
        check("sat_rev_evt",  {31'b0, evt_v[2]}, 0);

        // Load clamping, load over count, hold with en low.
        load = 1'b1; en = 1'b0; lv = 5'd13;
        run(1);
        check("clamp_m10w", dut_cnt(1), 9);
        check("noclamp_d16", dut_cnt(0), 13);
        en = 1'b1; lv = 5'd4;
        run(1);
        check("load_beats_en", dut_cnt(1), 4);
        load = 1'b0; en = 1'b0;
        run(10);
        check("hold_m10w", dut_cnt(1), 4);

        // ovf_clr without a boundary step, then on the same edge as a wrap.
        ovf_clr = 1'b1;
        run(1);
        check("ovf_clr_d16", {31'b0, ovf_v[0]}, 0);
        ovf_clr = 1'b0; load = 1'b1; lv = 5'd15;
        run(1);
        load = 1'b0; en = 1'b1; up_dn = 1'b1; ovf_clr = 1'b1;
        run(1);
        check("set_beats_clr", {31'b0, ovf_v[0]}, 1);
        ovf_clr = 1'b0;

        // Mid-count reset with en and load also asserted.
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(6);
        check("mid_pre_cnt", dut_cnt(0), 6);
        reset = 1'b1; load = 1'b1; lv = 5'd9;
        run(1);
        check("mid_rst_cnt", dut_cnt(0), 0);
        check("mid_rst_evt", {31'b0, evt_v[0]}, 0);
        check("mid_rst_ovf", {31'b0, ovf_v[0]}, 0);
        reset = 1'b0; load = 1'b0;
        run(1);
        check("mid_resume", dut_cnt(0), 1);

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            reset   = ($urandom_range(0, 39) == 0);
            load    = ($urandom_range(0, 7) == 0);
            en      = ($urandom_range(0, 3) != 0);
            up_dn   = ($urandom_range(0, 5) != 0) ? up_dn : ~up_dn;
            ovf_clr = ($urandom_range(0, 7) == 0);
            lv      = 5'($urandom_range(0, 31));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
